// File: rtl/tipi_pkg.sv
// tipi_pkg: shared definitions for the TIPI register bank.
//   DEF_BASE_ADDR / DEF_DATA_W : default address of TI-written register 0
//                                and default register width.
//   reg_dir_e                  : register direction (TI-written or host-written).
//   reg_addr()                 : TI bus address of register (channel, direction).
package tipi_pkg;

  localparam logic [15:0] DEF_BASE_ADDR = 16'h5FFF;
  localparam int unsigned DEF_DATA_W    = 8;

  typedef enum logic {
    DIR_TI_WR   = 1'b0,
    DIR_HOST_WR = 1'b1
  } reg_dir_e;

  // Registers sit on odd byte addresses counting down from the base:
  // all TI-written registers first, then all host-written registers.
  function automatic logic [15:0] reg_addr(input logic [15:0] base,
                                           input int unsigned num_ch,
                                           input int unsigned ch,
                                           input reg_dir_e    dir);
    int unsigned idx;
    idx = (dir == DIR_HOST_WR) ? (num_ch + ch) : ch;
    return base - 16'(2 * idx);
  endfunction

endpackage

// File: rtl/ti_bus_sync.sv
// ti_bus_sync: brings the asynchronous TI bus into the clk domain.
//   clk, rst              : system clock, synchronous active-high reset
//   ti_memen/ti_we/ti_dbin: raw TI strobes (memen/we active-low, dbin active-high)
//   ti_a, ti_data_in      : raw TI address (bit 0 = MSB) and write data
//   memen_s, dbin_s       : strobes after SYNC_STAGES flops
//   addr_s, data_s        : address/data captured alongside the last stage
//   we_fall               : synchronized WE 1->0 edge (combinational)
module ti_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ti_memen,
  input  logic              ti_we,
  input  logic              ti_dbin,
  input  logic [0:15]       ti_a,
  input  logic [DATA_W-1:0] ti_data_in,
  output logic              memen_s,
  output logic              dbin_s,
  output logic [15:0]       addr_s,
  output logic [DATA_W-1:0] data_s,
  output logic              we_fall
);

  logic [SYNC_STAGES-1:0] memen_q, memen_d;
  logic [SYNC_STAGES-1:0] we_q, we_d;
  logic [SYNC_STAGES-1:0] dbin_q, dbin_d;
  logic                   we_prev_q, we_prev_d;
  logic [SYNC_STAGES:0]   live_q, live_d;
  logic [15:0]            addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;

  always_comb begin
    memen_d   = {memen_q[SYNC_STAGES-2:0], ti_memen};
    we_d      = {we_q[SYNC_STAGES-2:0], ti_we};
    dbin_d    = {dbin_q[SYNC_STAGES-2:0], ti_dbin};
    we_prev_d = we_q[SYNC_STAGES-1];
    live_d    = {live_q[SYNC_STAGES-1:0], 1'b1};
    addr_d    = ti_a;
    data_d    = ti_data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memen_q   <= '1;
      we_q      <= '1;
      dbin_q    <= '0;
      we_prev_q <= 1'b1;
      live_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      memen_q   <= memen_d;
      we_q      <= we_d;
      dbin_q    <= dbin_d;
      we_prev_q <= we_prev_d;
      live_q    <= live_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign memen_s = memen_q[SYNC_STAGES-1];
  assign dbin_s  = dbin_q[SYNC_STAGES-1];
  assign addr_s  = addr_q;
  assign data_s  = data_q;

  // live_q marks when both edge-compare samples were taken after reset, so a
  // WE already low at reset release is never mistaken for a fresh fall.
  assign we_fall = live_q[SYNC_STAGES] & we_prev_q & ~we_q[SYNC_STAGES-1];

endmodule

// File: rtl/tipi_reg_bank.sv
// tipi_reg_bank: TI-bus mailbox registers shared with a host.
//   clk, rst                  : system clock, synchronous active-high reset
//   ti_a, ti_data_in          : TI address (bit 0 = MSB) and write data
//   ti_data_out, ti_data_oe   : registered read data and bus-drive enable
//   ti_memen, ti_we, ti_dbin  : asynchronous TI strobes
//   ti_cru_en                 : card enable, gates all decode
//   host_sel/we/wdata         : host write into host-written register [host_sel]
//   host_rdata                : TI-written register [host_sel], combinational
//   ti_wr_pulse, ti_wr_pend   : per-channel commit pulse and sticky pending flag
//   host_ack                  : per-channel pending clear
module tipi_reg_bank
  import tipi_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter logic [15:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [0:15]       ti_a,
  input  logic [DATA_W-1:0] ti_data_in,
  output logic [DATA_W-1:0] ti_data_out,
  output logic              ti_data_oe,
  input  logic              ti_memen,
  input  logic              ti_we,
  input  logic              ti_dbin,
  input  logic              ti_cru_en,
  input  logic [SEL_W-1:0]  host_sel,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic [NUM_CH-1:0] ti_wr_pulse,
  output logic [NUM_CH-1:0] ti_wr_pend,
  input  logic [NUM_CH-1:0] host_ack
);

  logic              memen_s, dbin_s, we_fall;
  logic [15:0]       addr_s;
  logic [DATA_W-1:0] data_s;

  ti_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (DATA_W)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .ti_memen  (ti_memen),
    .ti_we     (ti_we),
    .ti_dbin   (ti_dbin),
    .ti_a      (ti_a),
    .ti_data_in(ti_data_in),
    .memen_s   (memen_s),
    .dbin_s    (dbin_s),
    .addr_s    (addr_s),
    .data_s    (data_s),
    .we_fall   (we_fall)
  );

  logic [DATA_W-1:0] ti_reg_q   [NUM_CH];
  logic [DATA_W-1:0] ti_reg_d   [NUM_CH];
  logic [DATA_W-1:0] host_reg_q [NUM_CH];
  logic [DATA_W-1:0] host_reg_d [NUM_CH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_oe_q, rd_oe_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    ti_reg_d   = ti_reg_q;
    host_reg_d = host_reg_q;
    pulse_d    = '0;
    rd_data_d  = '0;
    rd_oe_d    = 1'b0;
    wr_ok      = we_fall & ~memen_s & ti_cru_en;
    rd_ok      = ~memen_s & dbin_s & ti_cru_en;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_s == reg_addr(BASE_ADDR, NUM_CH, i, DIR_TI_WR)) begin
        if (wr_ok) begin
          ti_reg_d[i] = data_s;
          pulse_d[i]  = 1'b1;
        end
        if (rd_ok) begin
          rd_oe_d   = 1'b1;
          rd_data_d = ti_reg_q[i];
        end
      end
      if (rd_ok && addr_s == reg_addr(BASE_ADDR, NUM_CH, i, DIR_HOST_WR)) begin
        rd_oe_d   = 1'b1;
        rd_data_d = host_reg_q[i];
      end
    end

    if (host_we && (32'(host_sel) < NUM_CH)) begin
      host_reg_d[host_sel] = host_wdata;
    end

    // A commit in the same cycle as an ack leaves the flag set.
    pend_d = (pend_q & ~host_ack) | pulse_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ti_reg_q   <= '{default: '0};
      host_reg_q <= '{default: '0};
      rd_data_q  <= '0;
      rd_oe_q    <= 1'b0;
      pulse_q    <= '0;
      pend_q     <= '0;
    end else begin
      ti_reg_q   <= ti_reg_d;
      host_reg_q <= host_reg_d;
      rd_data_q  <= rd_data_d;
      rd_oe_q    <= rd_oe_d;
      pulse_q    <= pulse_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    host_rdata = '0;
    if (32'(host_sel) < NUM_CH) begin
      host_rdata = ti_reg_q[host_sel];
    end
  end

  assign ti_data_out = rd_data_q;
  assign ti_data_oe  = rd_oe_q;
  assign ti_wr_pulse = pulse_q;
  assign ti_wr_pend  = pend_q;

endmodule
